// File: rtl/card_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : card_mem_pkg
//  Description : Shared card-RAM geometry, requester indices and arbiter
//                state encoding used by the card list engines.
//  Revision    : 1.0 - initial release
// ============================================================================
package card_mem_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 32;

    localparam int REQ_ALLOC  = 0;
    localparam int REQ_ADD    = 1;
    localparam int REQ_REMOVE = 2;
    localparam int REQ_SPLIT  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/card_ram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector: first set request at or
//                above the pointer, wrapping, as one-hot plus index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import card_mem_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    int   w_j;
    logic w_found;

    always_comb begin
        onehot  = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!w_found && req[w_j]) begin
                onehot[w_j] = 1'b1;
                idx         = PTR_W'(w_j);
                w_found     = 1'b1;
            end
        end
    end

    assign any = w_found;

endmodule
`default_nettype wire

// File: rtl/card_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : card_ram_arbiter
//  Description : Round-robin ownership arbiter for the shared 1024x32 card RAM.
//                Optional ownership timeout: define CARD_RAM_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module card_ram_arbiter
    import card_mem_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W
`ifdef CARD_RAM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        release_pulse,
    input  logic [NUM_REQ-1:0]        acc_valid,
    input  logic [NUM_REQ-1:0]        acc_wren,
    input  logic [NUM_REQ*ADDR_W-1:0] acc_addr,
    input  logic [NUM_REQ*DATA_W-1:0] acc_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [ADDR_W-1:0]         ram_address,
    output logic                      ram_clock,
    output logic [DATA_W-1:0]         ram_data,
    output logic                      ram_wren,
    input  logic [DATA_W-1:0]         ram_q
);

    localparam int         PTR_W      = ptr_width(NUM_REQ);
    localparam logic [1:0] C_ST_IDLE  = IDLE;
    localparam logic [1:0] C_ST_OWNED = OWNED;
    localparam logic [1:0] C_ST_DRAIN = DRAIN;

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rd_valid;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_owned;
    logic               w_acc_valid;
    logic               w_acc_wren;
    logic               w_rel;
    logic               w_exit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    assign w_owned     = (r_state == C_ST_OWNED);
    assign w_acc_valid = w_owned && acc_valid[r_owner];
    assign w_acc_wren  = acc_wren[r_owner];
    // A dropped request ends ownership exactly like an explicit release.
    assign w_rel       = release_pulse[r_owner] || !req[r_owner];
    assign w_ptr_next  = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef CARD_RAM_ARB_TIMEOUT_EN
    localparam int C_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_timeout_err;
    logic               w_timeout;

    assign w_timeout = w_owned && (r_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_exit    = w_owned && (w_rel || w_timeout);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout && !w_rel;
            if (r_state == C_ST_IDLE) begin
                r_cnt <= '0;
            end else if (w_owned) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_exit      = w_owned && w_rel;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= C_ST_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= (w_acc_valid && !w_acc_wren) ? r_gnt : '0;
            case (r_state)
                C_ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt   <= w_pick_onehot;
                        r_owner <= w_pick_idx;
                        r_state <= C_ST_OWNED;
                    end
                end
                C_ST_OWNED: begin
                    if (w_exit) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= C_ST_DRAIN;
                    end
                end
                C_ST_DRAIN: begin
                    r_state <= C_ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = ram_q;
    assign busy        = (r_state != C_ST_IDLE);
    assign ram_clock   = clock;
    assign ram_wren    = w_acc_valid && w_acc_wren;
    assign ram_address = w_owned ? acc_addr[r_owner*ADDR_W +: ADDR_W] : '0;
    assign ram_data    = w_owned ? acc_data[r_owner*DATA_W +: DATA_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_card_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_ram_arbiter
//  Description : Self-checking bench for card_ram_arbiter with a RAM model,
//                grant-order vector table and read-data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_card_ram_arbiter;
    import card_mem_pkg::*;

    localparam int N  = 4;
    localparam int AW = RAM_ADDR_W;
    localparam int DW = RAM_DATA_W;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    release_pulse = '0;
    logic [N-1:0]    acc_valid = '0;
    logic [N-1:0]    acc_wren = '0;
    logic [N*AW-1:0] acc_addr = '0;
    logic [N*DW-1:0] acc_data = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic            timeout_err;
    logic [AW-1:0]   ram_address;
    logic            ram_clock;
    logic [DW-1:0]   ram_data;
    logic            ram_wren;
    logic [DW-1:0]   ram_q = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0]  who;
        logic [DW-1:0] data;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  gnt;
        logic [AW-1:0] addr;
    } vec_t;
    vec_t vecs[8];

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];

    card_ram_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
`ifdef CARD_RAM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .release_pulse (release_pulse),
        .acc_valid     (acc_valid),
        .acc_wren      (acc_wren),
        .acc_addr      (acc_addr),
        .acc_data      (acc_data),
        .gnt           (gnt),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .ram_address   (ram_address),
        .ram_clock     (ram_clock),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .ram_q         (ram_q)
    );

    always #5 clock = ~clock;

    // Registered-read single-port RAM fixture.
    always @(posedge ram_clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && rd_valid != '0) begin
            if (sb.size() == 0) begin
                check("rd_valid_unexpected", 64'(rd_valid), 64'd0);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                check("sb_rd_valid", 64'(rd_valid), 64'(e.who));
                check("sb_rd_data", 64'(rd_data), 64'(e.data));
            end
        end
    end

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic clear_acc();
        acc_valid     = '0;
        acc_wren      = '0;
        acc_addr      = '0;
        acc_data      = '0;
        release_pulse = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        clear_acc();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // One access cycle from requester r; owner accesses update the reference model.
    task automatic access(input int r, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input bit rel, input bit is_owner);
        rd_exp_t e;
        clear_acc();
        acc_valid[r]           = 1'b1;
        acc_wren[r]            = wr;
        acc_addr[r*AW +: AW]   = addr;
        acc_data[r*DW +: DW]   = data;
        release_pulse[r]       = rel;
        #1;
        if (is_owner) begin
            check("ram_wren", 64'(ram_wren), 64'(wr));
            check("ram_address", 64'(ram_address), 64'(addr));
            if (wr) begin
                check("ram_data", 64'(ram_data), 64'(data));
                ref_mem[addr] = data;
            end else begin
                e.who  = N'(1) << r;
                e.data = ref_mem[addr];
                sb.push_back(e);
            end
        end else begin
            check("ram_wren_nonowner", 64'(ram_wren), 64'd0);
        end
        @(negedge clock);
        clear_acc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int own;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hA5A5_0000 | 32'(i);
            ref_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        vecs[0] = '{4'b1111, 4'b0001, 10'h010};
        vecs[1] = '{4'b1111, 4'b0010, 10'h011};
        vecs[2] = '{4'b1111, 4'b0100, 10'h3FF};
        vecs[3] = '{4'b1111, 4'b1000, 10'h013};
        vecs[4] = '{4'b1111, 4'b0001, 10'h014};
        vecs[5] = '{4'b1001, 4'b1000, 10'h015};
        vecs[6] = '{4'b0110, 4'b0010, 10'h016};
        vecs[7] = '{4'b0011, 4'b0001, 10'h017};

        do_reset();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_ram_wren", 64'(ram_wren), 64'd0);
        check("rst_ram_address", 64'(ram_address), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);

        // Single requester: write then read back.
        req = 4'b0010;
        @(negedge clock);
        check("t1_gnt", 64'(gnt), 64'b0010);
        check("t1_busy", 64'(busy), 64'd1);
        access(1, 1'b1, 10'h040, 32'h8000_0000, 1'b0, 1'b1);
        access(1, 1'b0, 10'h040, 32'h0, 1'b0, 1'b1);
        check("t1_rd_valid", 64'(rd_valid), 64'b0010);
        check("t1_rd_data", 64'(rd_data), 64'h8000_0000);
        release_pulse = 4'b0010;
        @(negedge clock);
        release_pulse = '0;
        req = '0;
        check("t1_drain_gnt", 64'(gnt), 64'd0);
        check("t1_drain_busy", 64'(busy), 64'd1);
        @(negedge clock);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Grant order table; each owner reads once and releases in the same cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            @(negedge clock);
            check("grant_order", 64'(gnt), 64'(vecs[i].gnt));
            check("busy_owned", 64'(busy), 64'd1);
            own = onehot_idx(vecs[i].gnt);
            access(own, 1'b0, vecs[i].addr, 32'h0, 1'b1, 1'b1);
            check("gnt_drain", 64'(gnt), 64'd0);
            check("rd_valid_drain", 64'(rd_valid), 64'(vecs[i].gnt));
            req = '0;
            @(negedge clock);
            check("busy_idle", 64'(busy), 64'd0);
        end

        // Non-owner access is ignored.
        req = 4'b0001;
        @(negedge clock);
        check("t4_gnt", 64'(gnt), 64'b0001);
        acc_valid = 4'b1001;
        acc_wren  = 4'b1001;
        acc_addr[0*AW +: AW] = 10'h100;
        acc_addr[3*AW +: AW] = 10'h200;
        acc_data[0*DW +: DW] = 32'h1234_5678;
        acc_data[3*DW +: DW] = 32'hDEAD_BEEF;
        #1;
        check("t4_ram_wren", 64'(ram_wren), 64'd1);
        check("t4_ram_address", 64'(ram_address), 64'h100);
        check("t4_ram_data", 64'(ram_data), 64'h1234_5678);
        ref_mem[10'h100] = 32'h1234_5678;
        @(negedge clock);
        clear_acc();
        access(REQ_SPLIT, 1'b1, 10'h200, 32'hDEAD_BEEF, 1'b0, 1'b0);
        access(REQ_ALLOC, 1'b0, 10'h200, 32'h0, 1'b0, 1'b1);
        access(REQ_ALLOC, 1'b0, 10'h100, 32'h0, 1'b1, 1'b1);
        req = '0;
        check("t4_drain_gnt", 64'(gnt), 64'd0);
        @(negedge clock);

        // Reset during ownership squashes the pending read.
        req = 4'b0010;
        @(negedge clock);
        check("t5_gnt", 64'(gnt), 64'b0010);
        access(REQ_ADD, 1'b1, 10'h050, 32'hCAFE_0001, 1'b0, 1'b1);
        acc_valid[1] = 1'b1;
        acc_addr[1*AW +: AW] = 10'h051;
        reset = 1'b1;
        @(negedge clock);
        check("t5_gnt", 64'(gnt), 64'd0);
        check("t5_ram_wren", 64'(ram_wren), 64'd0);
        check("t5_rd_valid", 64'(rd_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        clear_acc();
        reset = 1'b0;
        req = 4'b1111;
        @(negedge clock);
        check("t5_ptr_zero", 64'(gnt), 64'b0001);
        access(REQ_ALLOC, 1'b0, 10'h050, 32'h0, 1'b0, 1'b1);
        req = '0;
        @(negedge clock);
        check("t5_drop_gnt", 64'(gnt), 64'd0);
        check("t5_drop_busy", 64'(busy), 64'd1);
        @(negedge clock);

`ifdef CARD_RAM_ARB_TIMEOUT_EN
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            check("to_hold_gnt", 64'(gnt), 64'b0001);
            check("to_hold_err", 64'(timeout_err), 64'd0);
        end
        @(negedge clock);
        check("to_revoke_gnt", 64'(gnt), 64'd0);
        check("to_err_pulse", 64'(timeout_err), 64'd1);
        @(negedge clock);
        check("to_err_clear", 64'(timeout_err), 64'd0);
        @(negedge clock);
        check("to_next_gnt", 64'(gnt), 64'b0010);
        req = '0;
        repeat (3) @(negedge clock);
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/card_ram_arbiter.md
Name: card_ram_arbiter

Overview:
Shares the single-port 1024x32 card RAM (ram1024x32) between up to NUM_REQ list-operation engines: allocator, add_card, remove_nth_card and split_list.
- Grants exclusive ownership to one requester at a time, with round-robin fairness.
- Muxes the owner's access onto the RAM port and routes read data back to that owner with a valid strobe.
- Replaces ad-hoc per-operation RAM muxing inside the RAM controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 10, RAM address width
DATA_W, 32, RAM data width
TIMEOUT_CYCLES, 1024, max ownership length (used only with optional feature)

Ports:
clock  in  1  system clock, also forwarded to RAM
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  requester i wants ownership; held until granted
release  in  NUM_REQ  one-cycle pulse: owner ends ownership
acc_valid  in  NUM_REQ  requester i issues a RAM access this cycle
acc_wren  in  NUM_REQ  1 = write, 0 = read
acc_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
acc_data  in  NUM_REQ*DATA_W  flattened write data
gnt  out  NUM_REQ  one-hot owner, registered
rd_valid  out  NUM_REQ  one-hot; read data for requester i valid this cycle
rd_data  out  DATA_W  read data (ram_q passthrough)
busy  out  1  high whenever the FSM is not in IDLE
timeout_err  out  1  one-cycle pulse on forced revoke (optional feature)
ram_address  out  ADDR_W  to RAM
ram_clock  out  1  equals clock
ram_data  out  DATA_W  to RAM
ram_wren  out  1  to RAM
ram_q  in  DATA_W  from RAM

Behaviour:
- Reset values: state IDLE, gnt=0, rd_valid=0, busy=0, timeout_err=0, round-robin pointer=0.
  - ram_wren=0 and ram_address=0 follow combinationally from gnt=0.
- FSM states IDLE, OWNED, DRAIN.
  - IDLE: if any req bit is set, select the first set bit searching from the pointer upward (wrapping). Register gnt = that one-hot and go to OWNED. Request-to-grant latency is 1 cycle.
  - OWNED: the owner's acc_* drive the RAM combinationally.
    - ram_wren = acc_valid[o] & acc_wren[o]; ram_address/ram_data = owner slice.
    - acc_valid from non-owners is ignored; no RAM effect.
    - Exit to DRAIN when release[o]=1 or req[o]=0 (a dropped req is treated as a release).
    - The pointer becomes (o+1) mod NUM_REQ on exit.
  - DRAIN: gnt=0, ram_wren=0, one cycle; lets the final read return. Then IDLE. No new grant is made in DRAIN.
- Read timing: a read accepted at edge N gives rd_valid[o]=1 and rd_data valid during cycle N+1. rd_valid is a registered copy of (owner & acc_valid & ~acc_wren).
  - Back-to-back reads sustain 1 per cycle.
  - A write is complete at the accepting edge.
- Same-cycle release and acc_valid: the access is performed, then ownership ends. A read issued that cycle still returns its rd_valid in DRAIN.
- release from a non-owner, or in IDLE/DRAIN: ignored.
- Outside OWNED: ram_address=0, ram_data=0, ram_wren=0.
- Reset mid-ownership: at the next edge gnt=0, so ram_wren drops and any pending rd_valid is squashed (0).
- NUM_REQ=1: always re-grants requester 0 after DRAIN.

Optional Feature:
CARD_RAM_ARB_TIMEOUT_EN:
- Defined: a counter clears on grant and increments each OWNED cycle. At TIMEOUT_CYCLES-1 the owner is revoked: go to DRAIN, pulse timeout_err, advance the pointer.
- Undefined: no counter; ownership is unbounded; timeout_err is tied 0.

Decomposition:
- Shared package card_mem_pkg holds:
  - RAM_ADDR_W=10, RAM_DATA_W=32;
  - requester index constants REQ_ALLOC=0, REQ_ADD=1, REQ_REMOVE=2, REQ_SPLIT=3;
  - the arb_state_t enum {IDLE, OWNED, DRAIN}.
- One sub-module, rr_pick: combinational round-robin selector. Inputs req vector and pointer; outputs one-hot and index.

Test Plan:
1. Reset, then req=4'b0010 → gnt=4'b0010 one cycle later, busy=1. Write addr 0x040 data 0x8000_0000, then read 0x040 → rd_valid[1]=1 next cycle, rd_data=0x8000_0000.
2. req=4'b1111 held, each owner releases after 1 access → grant order 0,1,2,3,0. Each grant is separated by one DRAIN cycle with gnt=0.
3. Owner 2 asserts release together with a read of 0x3FF → RAM reads 0x3FF; rd_valid[2]=1 in the DRAIN cycle; gnt=0 that cycle.
4. Requester 3 drives acc_valid/acc_wren=1 while 0 owns → ram_wren follows only owner 0. A later read shows the address requester 3 targeted is unchanged.
5. Assert reset while owner 1 writes every cycle → next cycle gnt=0, ram_wren=0, rd_valid=0, pointer=0.
6. With CARD_RAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, owner holds indefinitely → revoked after 8 OWNED cycles, timeout_err pulses once, next requester granted.
